// File: rtl/sign_accum32.sv
// Signed accumulator behind the conditional-inversion stage: completes the two's-complement
// conversion via carry-in and sums NTERMS terms per group with a backpressured result register.
module sign_accum32 #(
    parameter int unsigned NTERMS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_mag,
    input  logic        in_sign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_ovf
);

    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = (NTERMS > 2) ? $clog2(NTERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NTERMS - 1);

    logic [DW-1:0]    x1;
    logic             c1;
    logic             v1;
    logic [DW-1:0]    acc;
    logic             ovf_acc;
    logic [CNT_W-1:0] cnt;

    logic             last;
    logic             adv;
    logic [DW-1:0]    addend;
    logic [DW-1:0]    sum;
    logic             ovf;

    // Only the final term of a group can stall, and only on a full, unaccepted result.
    always_comb begin
        last     = (cnt == LAST_CNT);
        adv      = !(last && out_valid && !out_ready);
        in_ready = !rst && (!v1 || adv);
        addend   = x1 + DW'(c1);
        sum      = acc + x1 + DW'(c1);
        ovf      = (acc[DW-1] == addend[DW-1]) && (sum[DW-1] != acc[DW-1]);
    end

    // S1: one's-complement of the magnitude; sign is carried forward as carry-in.
    always_ff @(posedge clk) begin
        if (rst) begin
            x1 <= '0;
            c1 <= 1'b0;
            v1 <= 1'b0;
        end else if (in_valid && in_ready) begin
            x1 <= in_mag ^ {DW{in_sign}};
            c1 <= in_sign;
            v1 <= 1'b1;
        end else if (v1 && adv) begin
            v1 <= 1'b0;
        end
    end

    // S2: accumulate, and on the final term publish the group result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            ovf_acc   <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (v1 && adv) begin
                if (last) begin
                    out_sum   <= sum;
                    out_ovf   <= ovf_acc | ovf;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    ovf_acc   <= 1'b0;
                    cnt       <= '0;
                end else begin
                    acc     <= sum;
                    ovf_acc <= ovf_acc | ovf;
                    cnt     <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
